// File: rtl/simd_ram_responder.sv
// Vector data-memory responder: byte-enabled 256-bit RAM with fixed read latency,
// out-of-range flagging and saturating access counters. Macro SIMD_RAM_ZERO_INIT_EN adds a post-reset zero-fill sweep.
module simd_ram_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [13:0]  address_RAM,
    input  logic [31:0]  byteena_RAM,
    input  logic [255:0] writeData_RAM,
    input  logic         rden_RAM,
    input  logic         wren_RAM,
    output logic [255:0] readData_RAM,
    output logic         rvalid,
    output logic         busy,
    output logic         oob_err,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [14:0] LP_DEPTH = 15'(DEPTH);

    logic [255:0]  r_mem [DEPTH];
    logic          w_run;
    logic          w_in_range;
    logic          w_rd_req;
    logic          w_rd_fire;
    logic          w_wr_fire;
    logic          w_oob_req;
    logic [AW-1:0] w_idx;

    logic          r_s1_valid;
    logic [255:0]  r_s1_data;
    logic          r_oob;
    logic [15:0]   r_rd_cnt;
    logic [15:0]   r_wr_cnt;

    assign w_in_range = ({1'b0, address_RAM} < LP_DEPTH);
    assign w_idx      = address_RAM[AW-1:0];
    assign w_rd_req   = w_run & rden_RAM;
    assign w_rd_fire  = w_rd_req & w_in_range;
    assign w_wr_fire  = w_run & wren_RAM & w_in_range;
    assign w_oob_req  = w_run & (rden_RAM | wren_RAM) & ~w_in_range;

`ifdef SIMD_RAM_ZERO_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_sweep;
    logic          w_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sweep <= '0;
        end else if (r_state == ST_INIT) begin
            r_sweep <= r_sweep + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_sweep == LP_LAST) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_comb begin
        w_busy = (r_state == ST_INIT);
        w_run  = (r_state == ST_RUN);
    end

    assign busy = w_busy;
`else
    assign w_run = 1'b1;
    assign busy  = 1'b0;
`endif

    // Storage has no reset; the zero-fill sweep (when built in) shares the write port.
    always_ff @(posedge clk) begin
`ifdef SIMD_RAM_ZERO_INIT_EN
        if (w_busy) r_mem[r_sweep] <= '0;
        else
`endif
        if (w_wr_fire) begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (byteena_RAM[i]) r_mem[w_idx][8*i +: 8] <= writeData_RAM[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_req;
            if (w_rd_req) r_s1_data <= w_in_range ? r_mem[w_idx] : '0;
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            logic         r_s2_valid;
            logic [255:0] r_s2_data;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) r_s2_data <= r_s1_data;
                end
            end

            assign readData_RAM = r_s2_data;
            assign rvalid       = r_s2_valid;
        end else begin : g_lat1
            assign readData_RAM = r_s1_data;
            assign rvalid       = r_s1_valid;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_oob    <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_oob_req) r_oob <= 1'b1;
            if (w_rd_fire && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_wr_fire && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
        end
    end

    assign oob_err  = r_oob;
    assign rd_count = r_rd_cnt;
    assign wr_count = r_wr_cnt;

endmodule

// File: tb/tb_simd_ram_responder.sv
// Directed bench for simd_ram_responder: one READ_LATENCY=1 and one READ_LATENCY=2 instance on shared inputs.
module tb_simd_ram_responder;

`ifdef SIMD_RAM_ZERO_INIT_EN
    localparam logic EXP_BUSY = 1'b1;
    localparam int   EXP_FILL = 1024;
`else
    localparam logic EXP_BUSY = 1'b0;
    localparam int   EXP_FILL = 0;
`endif

    typedef struct {
        logic         rd;
        logic         wr;
        logic [13:0]  addr;
        logic [31:0]  be;
        logic [255:0] wd;
        logic         ev;
        logic [255:0] ed;
        logic [15:0]  erc;
        logic [15:0]  ewc;
        logic         eoob;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [13:0]  addr = '0;
    logic [31:0]  be = '0;
    logic [255:0] wd = '0;
    logic         rd = 1'b0;
    logic         wr = 1'b0;

    logic [255:0] d1, d2;
    logic         v1, v2, b1, b2, o1, o2;
    logic [15:0]  rc1, rc2, wc1, wc2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    simd_ram_responder #(.DEPTH(1024), .READ_LATENCY(1)) u_dut (
        .clk(clk), .reset(rst_n), .address_RAM(addr), .byteena_RAM(be),
        .writeData_RAM(wd), .rden_RAM(rd), .wren_RAM(wr), .readData_RAM(d1),
        .rvalid(v1), .busy(b1), .oob_err(o1), .rd_count(rc1), .wr_count(wc1)
    );

    simd_ram_responder #(.DEPTH(1024), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(rst_n), .address_RAM(addr), .byteena_RAM(be),
        .writeData_RAM(wd), .rden_RAM(rd), .wren_RAM(wr), .readData_RAM(d2),
        .rvalid(v2), .busy(b2), .oob_err(o2), .rd_count(rc2), .wr_count(wc2)
    );

    function automatic logic [255:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    function automatic vec_t mk(input logic r, input logic w, input logic [13:0] a,
                                input logic [31:0] e, input logic [255:0] dat,
                                input logic ev, input logic [255:0] ed,
                                input logic [15:0] erc, input logic [15:0] ewc, input logic eoob);
        vec_t t;
        t.rd = r; t.wr = w; t.addr = a; t.be = e; t.wd = dat;
        t.ev = ev; t.ed = ed; t.erc = erc; t.ewc = ewc; t.eoob = eoob;
        return t;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [13:0] a,
                         input logic [31:0] e, input logic [255:0] dat);
        rd = r; wr = w; addr = a; be = e; wd = dat;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (b1 && n < 5000) begin
            step();
            n++;
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, ".rvalid1"}, 256'(v1), 256'(1'b0));
        chk({tag, ".rvalid2"}, 256'(v2), 256'(1'b0));
        chk({tag, ".data1"}, d1, '0);
        chk({tag, ".data2"}, d2, '0);
        chk({tag, ".oob1"}, 256'(o1), 256'(1'b0));
        chk({tag, ".rdcnt1"}, 256'(rc1), 256'(0));
        chk({tag, ".wrcnt1"}, 256'(wc1), 256'(0));
        chk({tag, ".rdcnt2"}, 256'(rc2), 256'(0));
        chk({tag, ".busy1"}, 256'(b1), 256'(EXP_BUSY));
        chk({tag, ".busy2"}, 256'(b2), 256'(EXP_BUSY));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        logic         prev_v;
        logic [255:0] prev_d;
        logic [255:0] ff_lo0;
        int           n;

        ff_lo0 = {{28{8'hFF}}, 32'h0};
        //                rd wr addr        be            wd          ev  ed          rc  wc  oob
        vecs.push_back(mk(0, 1, 14'd5,    32'hFFFFFFFF, rep(8'hFF), 0, '0,         0,  1, 0));
        vecs.push_back(mk(0, 1, 14'd5,    32'h0000000F, '0,         0, '0,         0,  2, 0));
        vecs.push_back(mk(1, 0, 14'd5,    '0,           '0,         1, ff_lo0,     1,  2, 0));
        vecs.push_back(mk(0, 0, 14'd0,    '0,           '0,         0, ff_lo0,     1,  2, 0));
        vecs.push_back(mk(0, 1, 14'd7,    32'hFFFFFFFF, rep(8'hA5), 0, ff_lo0,     1,  3, 0));
        vecs.push_back(mk(1, 1, 14'd7,    32'hFFFFFFFF, rep(8'h3C), 1, rep(8'hA5), 2,  4, 0));
        vecs.push_back(mk(1, 0, 14'd7,    '0,           '0,         1, rep(8'h3C), 3,  4, 0));
        vecs.push_back(mk(0, 1, 14'd0,    32'hFFFFFFFF, rep(8'h11), 0, rep(8'h3C), 3,  5, 0));
        vecs.push_back(mk(0, 1, 14'd1024, 32'hFFFFFFFF, rep(8'hEE), 0, rep(8'h3C), 3,  5, 1));
        vecs.push_back(mk(1, 0, 14'd1024, '0,           '0,         1, '0,         3,  5, 1));
        vecs.push_back(mk(1, 0, 14'd0,    '0,           '0,         1, rep(8'h11), 4,  5, 1));
        vecs.push_back(mk(0, 1, 14'd1,    32'hFFFFFFFF, rep(8'h01), 0, rep(8'h11), 4,  6, 1));
        vecs.push_back(mk(0, 1, 14'd2,    32'hFFFFFFFF, rep(8'h02), 0, rep(8'h11), 4,  7, 1));
        vecs.push_back(mk(0, 1, 14'd3,    32'hFFFFFFFF, rep(8'h03), 0, rep(8'h11), 4,  8, 1));
        vecs.push_back(mk(1, 0, 14'd1,    '0,           '0,         1, rep(8'h01), 5,  8, 1));
        vecs.push_back(mk(1, 0, 14'd2,    '0,           '0,         1, rep(8'h02), 6,  8, 1));
        vecs.push_back(mk(1, 0, 14'd3,    '0,           '0,         1, rep(8'h03), 7,  8, 1));
        vecs.push_back(mk(0, 0, 14'd0,    '0,           '0,         0, rep(8'h03), 7,  8, 1));
        vecs.push_back(mk(0, 1, 14'd1,    32'h00000000, rep(8'hFF), 0, rep(8'h03), 7,  9, 1));
        vecs.push_back(mk(1, 0, 14'd1,    '0,           '0,         1, rep(8'h01), 8,  9, 1));
        vecs.push_back(mk(0, 1, 14'd9,    32'hFFFFFFFF, rep(8'h5A), 0, rep(8'h01), 8, 10, 1));
        vecs.push_back(mk(1, 0, 14'd9,    '0,           '0,         1, rep(8'h5A), 9, 10, 1));
        vecs.push_back(mk(1, 0, 14'h3FFF, '0,           '0,         1, '0,         9, 10, 1));
        vecs.push_back(mk(0, 0, 14'd0,    '0,           '0,         0, '0,         9, 10, 1));

        // Reset state, then the zero-fill window
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        chk("fill_cycles", 256'(n), 256'(EXP_FILL));
        chk("fill_busy2", 256'(b2), 256'(1'b0));

        prev_v = 1'b0;
        prev_d = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd);
            step();
            chk($sformatf("v%0d.rvalid1", i), 256'(v1), 256'(vecs[i].ev));
            chk($sformatf("v%0d.data1", i), d1, vecs[i].ed);
            chk($sformatf("v%0d.rdcnt", i), 256'(rc1), 256'(vecs[i].erc));
            chk($sformatf("v%0d.wrcnt", i), 256'(wc1), 256'(vecs[i].ewc));
            chk($sformatf("v%0d.oob", i), 256'(o1), 256'(vecs[i].eoob));
            chk($sformatf("v%0d.rvalid2", i), 256'(v2), 256'(prev_v));
            chk($sformatf("v%0d.data2", i), d2, prev_d);
            chk($sformatf("v%0d.wrcnt2", i), 256'(wc2), 256'(vecs[i].ewc));
            prev_v = vecs[i].ev;
            prev_d = vecs[i].ed;
        end

        // Asynchronous reset with reads in flight in both pipelines
        drive(1, 0, 14'd2, '0, '0);
        @(posedge clk);
        drive(1, 0, 14'd3, '0, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        @(negedge clk);
        drive(0, 0, 14'd0, '0, '0);
        step();
        step();
        check_cleared("midrst_hold");
        rst_n = 1'b1;

`ifdef SIMD_RAM_ZERO_INIT_EN
        // Reset again 500 cycles into the sweep; a full sweep must follow
        repeat (500) step();
        chk("sweep500_busy", 256'(b1), 256'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("sweeprst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        chk("refill_cycles", 256'(n), 256'(1024));
        drive(0, 1, 14'd6, 32'hFFFFFFFF, rep(8'h77));
        step();
        drive(1, 0, 14'd6, '0, '0);
        step();
        chk("rf6.rvalid", 256'(v1), 256'(1'b1));
        chk("rf6.data", d1, rep(8'h77));
        drive(1, 0, 14'h3FF, '0, '0);
        step();
        chk("rf3ff.rvalid", 256'(v1), 256'(1'b1));
        chk("rf3ff.data", d1, '0);
        drive(1, 0, 14'd5, '0, '0);
        step();
        chk("rf5.data", d1, '0);
        drive(0, 0, 14'd0, '0, '0);
`else
        wait_ready(n);
        chk("nofill_cycles", 256'(n), 256'(0));
`endif

        // Counter saturation
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("satrst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        drive(1, 1, 14'd0, 32'h0, '0);
        repeat (65534) step();
        chk("sat.rd_fffe", 256'(rc1), 256'(16'hFFFE));
        chk("sat.wr_fffe", 256'(wc1), 256'(16'hFFFE));
        repeat (6) step();
        chk("sat.rd_ffff", 256'(rc1), 256'(16'hFFFF));
        chk("sat.wr_ffff", 256'(wc1), 256'(16'hFFFF));
        chk("sat.rd2_ffff", 256'(rc2), 256'(16'hFFFF));
        chk("sat.wr2_ffff", 256'(wc2), 256'(16'hFFFF));
        drive(0, 0, 14'd0, '0, '0);
        step();
        chk("sat.rd_hold", 256'(rc1), 256'(16'hFFFF));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
